sar_adc_ctrl: RTL and testbench
===============================

Name: sar_adc_ctrl

Overview:
Digital successive-approximation controller that sits directly upstream of the analog macro on the ua[] pins. It drives the macro's sample switch and capacitive-DAC code, then consumes the macro's comparator output bit-serially to build a WIDTH-bit conversion result. It exposes a simple start/done handshake to the surrounding digital logic, which maps onto ui_in/uo_out.

Parameters:
WIDTH, 8, result and DAC code width in bits (legal range 2..12)
SAMPLE_CYCLES, 4, cycles sample_en is held high per conversion (>=1)
SETTLE_CYCLES, 1, DAC settle cycles before each comparator read (>=1)

Ports:
clk  input  1  single system clock
rst  input  1  synchronous active-high reset
start  input  1  request a conversion; level-sampled in IDLE or DONE only
abort  input  1  cancel the conversion in progress
cmp_in  input  1  comparator output from the analog macro; 1 = Vin >= Vdac
sample_en  output  1  closes the sample switch on the analog macro
dac_code  output  WIDTH  trial code to the capacitive DAC
busy  output  1  high in SAMPLE, SETTLE and COMPARE
done  output  1  one-cycle pulse when result updates
result  output  WIDTH  last completed conversion, held until the next done

Behaviour:
- Clocking and reset: one clock (clk); reset (rst) is synchronous, active-high. All outputs are registered.
- Reset values: state=IDLE; sample_en=0; dac_code=0; busy=0; done=0; result=0; bit index=WIDTH-1; all counters=0.
- Reset asserted mid-conversion forces reset values on the next edge. No done pulse; result is cleared.
- States: IDLE, SAMPLE, SETTLE, COMPARE, DONE.
- IDLE:
  - dac_code=0, sample_en=0.
  - start=1 -> SAMPLE.
- SAMPLE:
  - sample_en=1, dac_code=0, busy=1, held for exactly SAMPLE_CYCLES cycles.
  - Then -> SETTLE with bit index i=WIDTH-1 and dac_code = 1<<(WIDTH-1).
- SETTLE:
  - dac_code = accumulated | (1<<i), held for SETTLE_CYCLES cycles.
  - Then -> COMPARE.
- COMPARE (1 cycle):
  - Samples cmp_in. 1 keeps bit i in the accumulator; 0 clears it.
  - If i>0: i decrements, and the next SETTLE presents the new trial code on the same edge.
  - If i=0: the final accumulator is written to result, done=1 -> DONE.
- DONE (1 cycle):
  - done=1, busy=0, dac_code=0.
  - start=1 here -> SAMPLE (back-to-back conversion); otherwise -> IDLE.
- Latency: start seen at edge T gives done high in cycle T + SAMPLE_CYCLES + WIDTH*(SETTLE_CYCLES+1). With defaults this is T+20; each conversion occupies 21 cycles including DONE.
- start while busy is ignored; no queueing.
- abort=1 in SAMPLE/SETTLE/COMPARE -> IDLE on the next edge.
  - result unchanged, no done, sample_en and dac_code return to 0.
  - abort has priority over the COMPARE-to-DONE transition.
  - abort in IDLE/DONE has no effect. If start and abort are both high in IDLE, start wins.
- Accumulator is WIDTH bits; no arithmetic carries. Comparator polarity is fixed as above.

Optional Feature:
SAR_CMP_SYNC_EN:
- Defined: cmp_in passes through a 2-flop synchronizer (both flops reset to 0). COMPARE samples the synchronizer output. SETTLE lasts SETTLE_CYCLES+2 cycles so the synchronized value reflects the current trial code. Latency becomes SAMPLE_CYCLES + WIDTH*(SETTLE_CYCLES+3); with defaults this is 36.
- Undefined: cmp_in is sampled directly in COMPARE (the analog macro is then clocked by clk). No extra flops.

Test Plan:
- Behavioral comparator cmp_in = (VIN >= dac_code), VIN=0xA5; pulse start for 1 cycle -> busy for 20 cycles, sample_en high for exactly 4 cycles; dac_code trials 0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5; done pulse 20 cycles after start edge; result=0xA5.
- VIN=0x00 then VIN=0xFF -> result=0x00 and 0xFF respectively; dac_code returns to 0 in DONE/IDLE.
- Hold start high continuously, VIN=0x3C -> done pulses exactly every 21 cycles; result=0x3C each time.
- Start with VIN=0x5A, assert abort during the 4th COMPARE -> IDLE next cycle, no done, result keeps the previous value; re-start -> 0x5A.
- Pulse start again while busy -> ignored, done timing unchanged; assert rst for 1 cycle mid-SETTLE -> all outputs at reset values next cycle, result=0.
- With SAR_CMP_SYNC_EN defined, VIN=0xA5 -> done 36 cycles after the start edge; result=0xA5.

Source files
------------

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller: sample switch, cap-DAC trial codes, bit-serial result build.
// Latency: start edge T -> done in cycle T+SAMPLE_CYCLES+WIDTH*(SETTLE_CYCLES+1) (+2 settle/bit with SAR_CMP_SYNC_EN).
// No backpressure: start is ignored while busy, abort cancels a conversion; result held until the next done.
module sar_adc_ctrl #(
  parameter int WIDTH         = 8,
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             cmp_in,
  output logic             sample_en,
  output logic [WIDTH-1:0] dac_code,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

`ifdef SAR_CMP_SYNC_EN
  // Two extra settle cycles let the synchronizer catch up with the current trial code.
  localparam int SETTLE_LEN = SETTLE_CYCLES + 2;
`else
  localparam int SETTLE_LEN = SETTLE_CYCLES;
`endif
  localparam int CNT_MAX = (SAMPLE_CYCLES > SETTLE_LEN) ? SAMPLE_CYCLES : SETTLE_LEN;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = $clog2(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_SETTLE,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [IDX_W-1:0]   bit_idx, bit_idx_nxt;
  logic [WIDTH-1:0]   acc, acc_nxt;
  logic               sample_en_nxt;
  logic [WIDTH-1:0]   dac_code_nxt;
  logic               busy_nxt;
  logic               done_nxt;
  logic [WIDTH-1:0]   result_nxt;
  logic [WIDTH-1:0]   bit_mask;
  logic [WIDTH-1:0]   trial;
  logic [WIDTH-1:0]   kept;
  logic               cmp_bit;

`ifdef SAR_CMP_SYNC_EN
  logic cmp_s1, cmp_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_s1 <= 1'b0;
      cmp_s2 <= 1'b0;
    end else begin
      cmp_s1 <= cmp_in;
      cmp_s2 <= cmp_s1;
    end
  end

  assign cmp_bit = cmp_s2;
`else
  assign cmp_bit = cmp_in;
`endif

  // acc holds only resolved bits; the bit under test is ORed in for the trial.
  assign bit_mask = {{(WIDTH-1){1'b0}}, 1'b1} << bit_idx;
  assign trial    = acc | bit_mask;
  assign kept     = cmp_bit ? trial : acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= IDX_W'(WIDTH-1);
      acc       <= '0;
      sample_en <= 1'b0;
      dac_code  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bit_idx   <= bit_idx_nxt;
      acc       <= acc_nxt;
      sample_en <= sample_en_nxt;
      dac_code  <= dac_code_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      result    <= result_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    bit_idx_nxt   = bit_idx;
    acc_nxt       = acc;
    sample_en_nxt = 1'b0;
    dac_code_nxt  = '0;
    busy_nxt      = 1'b0;
    done_nxt      = 1'b0;
    result_nxt    = result;

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt     = S_SAMPLE;
          cnt_nxt       = '0;
          bit_idx_nxt   = IDX_W'(WIDTH-1);
          acc_nxt       = '0;
          sample_en_nxt = 1'b1;
          busy_nxt      = 1'b1;
        end else begin
          state_nxt = S_IDLE;
        end
      end

      S_SAMPLE: begin
        busy_nxt = 1'b1;
        if (cnt == CNT_W'(SAMPLE_CYCLES-1)) begin
          state_nxt    = S_SETTLE;
          cnt_nxt      = '0;
          dac_code_nxt = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
          cnt_nxt       = cnt + CNT_W'(1);
          sample_en_nxt = 1'b1;
        end
      end

      S_SETTLE: begin
        busy_nxt     = 1'b1;
        dac_code_nxt = trial;
        if (cnt == CNT_W'(SETTLE_LEN-1)) begin
          state_nxt = S_COMPARE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      S_COMPARE: begin
        if (bit_idx == '0) begin
          state_nxt  = S_DONE;
          result_nxt = kept;
          acc_nxt    = kept;
          done_nxt   = 1'b1;
        end else begin
          // Next trial code goes out on the same edge the decision is taken.
          state_nxt    = S_SETTLE;
          cnt_nxt      = '0;
          bit_idx_nxt  = bit_idx - IDX_W'(1);
          acc_nxt      = kept;
          busy_nxt     = 1'b1;
          dac_code_nxt = kept | (bit_mask >> 1);
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Abort wins over every in-flight transition, including COMPARE-to-DONE.
    if (abort && (state == S_SAMPLE || state == S_SETTLE || state == S_COMPARE)) begin
      state_nxt     = S_IDLE;
      cnt_nxt       = '0;
      bit_idx_nxt   = IDX_W'(WIDTH-1);
      acc_nxt       = acc;
      sample_en_nxt = 1'b0;
      dac_code_nxt  = '0;
      busy_nxt      = 1'b0;
      done_nxt      = 1'b0;
      result_nxt    = result;
    end
  end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Scoreboard bench for sar_adc_ctrl with a behavioural comparator (cmp_in = vin >= dac_code).
module tb_sar_adc_ctrl;
  localparam int W    = 8;
  localparam int SAMP = 4;
`ifdef SAR_CMP_SYNC_EN
  localparam int P = 4;
`else
  localparam int P = 2;
`endif
  localparam int LAT = SAMP + W * P;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         abort;
  logic         cmp_in;
  logic [W-1:0] vin;
  logic         sample_en;
  logic [W-1:0] dac_code;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  sar_adc_ctrl #(.WIDTH(W), .SAMPLE_CYCLES(SAMP), .SETTLE_CYCLES(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .cmp_in    (cmp_in),
    .sample_en (sample_en),
    .dac_code  (dac_code),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  assign cmp_in = (vin >= dac_code);

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [W-1:0] res;
    int           at;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && done) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_done: done=1 with no conversion pending, result=0x%0h (cycle %0d)", result, cyc);
        end else begin
          e = sb.pop_front();
          check("result", int'(result), int'(e.res));
          check("done_cycle", cyc, e.at);
          check("dac_in_done", int'(dac_code), 0);
          check("busy_in_done", int'(busy), 0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; the DUT sees start on the following posedge.
  task automatic issue(input logic [W-1:0] v, input logic [W-1:0] r, input bit expect_done);
    exp_t e;
    vin   = v;
    start = 1'b1;
    if (expect_done) begin
      e.res = r;
      e.at  = cyc + 1 + LAT;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain(input int maxc);
    int n;
    n = 0;
    while (sb.size() != 0 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb.size(), 0);
    if (sb.size() != 0) sb.delete();
    repeat (2) @(negedge clk);
  endtask

  logic [W-1:0] trial_exp [W];
  int t0, nse, nb, k, tgt;

  initial begin
    trial_exp = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    vin   = '0;
    repeat (2) @(negedge clk);
    check("rst_sample_en", int'(sample_en), 0);
    check("rst_dac_code", int'(dac_code), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_result", int'(result), 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic conversion, VIN=0xA5: trial sequence, sample window, busy length.
    t0 = cyc + 1;
    issue(8'hA5, 8'hA5, 1'b1);
    nse = 0;
    nb  = 0;
    for (int n = 0; n < LAT + 2; n++) begin
      if (sample_en) nse++;
      if (busy) nb++;
      if (n == 0) check("dac_in_sample", int'(dac_code), 0);
      if (n >= SAMP && ((n - SAMP) % P) == 0) begin
        k = (n - SAMP) / P;
        if (k < W) check($sformatf("trial%0d", k), int'(dac_code), int'(trial_exp[k]));
      end
      @(negedge clk);
    end
    check("sample_en_cycles", nse, SAMP);
    check("busy_cycles", nb, LAT);
    check("dac_idle", int'(dac_code), 0);
    wait_drain(10);

    // Rails.
    issue(8'h00, 8'h00, 1'b1);
    wait_drain(LAT + 5);
    check("dac_idle_after_00", int'(dac_code), 0);
    issue(8'hFF, 8'hFF, 1'b1);
    wait_drain(LAT + 5);
    check("dac_idle_after_ff", int'(dac_code), 0);

    // Start held high: back-to-back conversions every LAT+1 cycles.
    t0  = cyc + 1;
    vin = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      e.res = 8'h3C;
      e.at  = t0 + i * (LAT + 1) + LAT;
      sb.push_back(e);
    end
    start = 1'b1;
    tgt   = t0 + 2 * (LAT + 1) + LAT;
    while (cyc < tgt) @(negedge clk);
    start = 1'b0;
    wait_drain(10);

    // Abort during the 4th COMPARE: no done, result keeps 0x3C.
    t0 = cyc + 1;
    issue(8'h5A, 8'h00, 1'b0);
    tgt = t0 + SAMP + P * 3 + (P - 1);
    while (cyc < tgt) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_sample_en", int'(sample_en), 0);
    check("abort_dac", int'(dac_code), 0);
    check("abort_result_held", int'(result), 8'h3C);
    repeat (LAT + 5) @(negedge clk);
    check("abort_still_idle", int'(busy), 0);
    issue(8'h5A, 8'h5A, 1'b1);
    wait_drain(LAT + 5);

    // Start pulsed mid-conversion is ignored; done timing checked by the monitor.
    issue(8'h81, 8'h81, 1'b1);
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain(LAT + 5);
    repeat (LAT + 5) @(negedge clk);
    check("no_retrigger", int'(busy), 0);

    // Reset mid-SETTLE: everything back to reset values, no done.
    t0 = cyc + 1;
    issue(8'h77, 8'h00, 1'b0);
    tgt = t0 + SAMP + P;
    while (cyc < tgt) @(negedge clk);
    check("pre_rst_busy", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_sample_en", int'(sample_en), 0);
    check("mid_rst_dac", int'(dac_code), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_result", int'(result), 0);
    rst = 1'b0;
    repeat (LAT + 5) @(negedge clk);
    check("post_rst_idle", int'(busy), 0);
    issue(8'hC3, 8'hC3, 1'b1);
    wait_drain(LAT + 5);

    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
